// File: rtl/booth_mult_seq.sv
// Sequential radix-4 Booth multiplier, one digit per clock, start/busy/done handshake.
// Define BOOTH_UNSIGNED_MODE_EN to add the is_signed port (zero- or sign-extended operands).
module booth_mult_seq #(
  parameter int unsigned WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
`ifdef BOOTH_UNSIGNED_MODE_EN
  input  logic                 is_signed,
`endif
  input  logic [WIDTH-1:0]     multiplicand,
  input  logic [WIDTH-1:0]     multiplier,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

`ifdef BOOTH_UNSIGNED_MODE_EN
  localparam int unsigned W_INT = WIDTH + 2;
`else
  localparam int unsigned W_INT = WIDTH;
`endif
  localparam int unsigned N  = W_INT / 2;
  localparam int unsigned HW = W_INT + 2;
  localparam int unsigned CW = $clog2(N) + 1;
  localparam int unsigned PH = 2*WIDTH - W_INT;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_FINISH
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;

  logic [HW-1:0]       r_mcand;
  logic [HW-1:0]       r_acc;
  logic [W_INT-1:0]    r_mplr;
  logic                r_ylsb;
  logic [CW-1:0]       r_cnt;
  logic                r_busy;
  logic                r_done;
  logic [2*WIDTH-1:0]  r_product;

  logic                w_ext_sign;
  logic [HW-1:0]       w_a_ext;
  logic [W_INT-1:0]    w_b_ext;
  logic [2:0]          w_triplet;
  logic [HW-1:0]       w_m2;
  logic [HW-1:0]       w_pp;
  logic [HW-1:0]       w_sum;
  logic                w_last;

`ifdef BOOTH_UNSIGNED_MODE_EN
  assign w_ext_sign = is_signed;
  assign w_b_ext    = {{2{w_ext_sign & multiplier[WIDTH-1]}}, multiplier};
`else
  assign w_ext_sign = 1'b1;
  assign w_b_ext    = multiplier;
`endif
  assign w_a_ext = {{(HW-WIDTH){w_ext_sign & multiplicand[WIDTH-1]}}, multiplicand};

  assign w_triplet = {r_mplr[1:0], r_ylsb};
  assign w_m2      = {r_mcand[HW-2:0], 1'b0};
  assign w_last    = (r_cnt == CW'(N-1));

  // M is held W_INT+2 wide so that -2M stays representable even for the most-negative M.
  always_comb begin
    w_pp = '0;
    case (w_triplet)
      3'b001, 3'b010: w_pp = r_mcand;
      3'b011:         w_pp = w_m2;
      3'b100:         w_pp = -w_m2;
      3'b101, 3'b110: w_pp = -r_mcand;
      default:        w_pp = '0;
    endcase
  end

  assign w_sum = r_acc + w_pp;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (start) w_state_nxt = S_CALC;
      S_CALC:   if (w_last) w_state_nxt = S_FINISH;
      S_FINISH: w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mcand   <= '0;
      r_acc     <= '0;
      r_mplr    <= '0;
      r_ylsb    <= 1'b0;
      r_cnt     <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_product <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_mcand <= w_a_ext;
            r_acc   <= '0;
            r_mplr  <= w_b_ext;
            r_ylsb  <= 1'b0;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
          end
        end
        S_CALC: begin
          // {acc, mplr, ylsb} shifts right by two as a single arithmetic register.
          r_acc  <= {{2{w_sum[HW-1]}}, w_sum[HW-1:2]};
          r_mplr <= {w_sum[1:0], r_mplr[W_INT-1:2]};
          r_ylsb <= r_mplr[1];
          r_cnt  <= r_cnt + 1'b1;
        end
        S_FINISH: begin
          r_product <= {r_acc[PH-1:0], r_mplr};
          r_done    <= 1'b1;
          r_busy    <= 1'b0;
        end
        default: begin
          r_busy <= 1'b0;
        end
      endcase
    end
  end

  assign busy    = r_busy;
  assign done    = r_done;
  assign product = r_product;

endmodule

// File: tb/tb_booth_mult_seq.sv
// Scoreboard bench for booth_mult_seq (WIDTH=32); follows BOOTH_UNSIGNED_MODE_EN when defined.
module tb_booth_mult_seq;

`ifdef BOOTH_UNSIGNED_MODE_EN
  localparam int LAT = 18;
`else
  localparam int LAT = 17;
`endif

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        sgn_in;
  logic [31:0] a_in;
  logic [31:0] b_in;
  logic        busy;
  logic        done;
  logic [63:0] product;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int n_done = 0;
  int last_done_cyc = 0;
  int prev_done_cyc = 0;
  bit done_prev = 1'b0;

  logic signed [63:0] q_exp[$];
  int                 q_acc[$];

  booth_mult_seq #(.WIDTH(32)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
`ifdef BOOTH_UNSIGNED_MODE_EN
    .is_signed    (sgn_in),
`endif
    .multiplicand (a_in),
    .multiplier   (b_in),
    .busy         (busy),
    .done         (done),
    .product      (product)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: pops the scoreboard on every done pulse.
  always @(negedge clk) begin
    logic signed [63:0] exp_v;
    int                 acc_v;
    if (rst_n && done) begin
      n_done++;
      total++;
      if (busy) begin
        bad++;
        $display("FAIL busy_with_done busy=%0b required=0", busy);
      end
      total++;
      if (done_prev) begin
        bad++;
        $display("FAIL done_pulse prev_done=%0b required=0", done_prev);
      end
      if (q_exp.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_done product=%0h", product);
      end else begin
        exp_v = q_exp.pop_front();
        acc_v = q_acc.pop_front();
        total++;
        if ($signed(product) !== exp_v) begin
          bad++;
          $display("FAIL product got=%0h required=%0h", product, exp_v);
        end
        total++;
        if (cyc - acc_v != LAT) begin
          bad++;
          $display("FAIL latency got=%0d required=%0d", cyc - acc_v, LAT);
        end
      end
      prev_done_cyc = last_done_cyc;
      last_done_cyc = cyc;
    end
    done_prev = done;
  end

  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic sgn,
                       input logic signed [63:0] exp, input bit chk, input bit hold);
    int n;
    @(negedge clk);
    n = 0;
    while (busy && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (busy) begin
      total++;
      bad++;
      $display("FAIL issue_wait busy=%0b required=0", busy);
    end
    a_in   = a;
    b_in   = b;
    sgn_in = sgn;
    start  = 1'b1;
    if (chk) begin
      q_exp.push_back(exp);
      q_acc.push_back(cyc + 1);
    end
    @(posedge clk);
    #1;
    if (!hold) start = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 200 && q_exp.size() != 0; i++) @(negedge clk);
    @(negedge clk);
    total++;
    if (q_exp.size() != 0) begin
      bad++;
      $display("FAIL drain_timeout pending=%0d required=0", q_exp.size());
    end
  endtask

  task automatic check1(input string name, input logic [63:0] got, input logic [63:0] req);
    total++;
    if (got !== req) begin
      bad++;
      $display("FAIL %s got=%0h required=%0h", name, got, req);
    end
  endtask

  initial begin
    int n0;
    rst_n  = 1'b0;
    start  = 1'b0;
    sgn_in = 1'b1;
    a_in   = '0;
    b_in   = '0;
    repeat (2) @(negedge clk);
    check1("reset_busy", {63'd0, busy}, 64'd0);
    check1("reset_done", {63'd0, done}, 64'd0);
    check1("reset_product", product, 64'd0);
    rst_n = 1'b1;

    issue(32'd15, 32'd10, 1'b1, 64'sd150, 1'b1, 1'b0);
    @(negedge clk);
    check1("busy_after_accept", {63'd0, busy}, 64'd1);
    drain();

    issue(-32'sd25, 32'd3, 1'b1, -64'sd75, 1'b1, 1'b0);
    issue(32'd1000, -32'sd2000, 1'b1, -64'sd2000000, 1'b1, 1'b0);
    issue(-32'sd50000, -32'sd1000, 1'b1, 64'sd50000000, 1'b1, 1'b0);
    issue(32'd0, 32'd12345, 1'b1, 64'sd0, 1'b1, 1'b0);
    issue(-32'sd1, 32'h7FFF_FFFF, 1'b1, -64'sd2147483647, 1'b1, 1'b0);
    issue(32'h8000_0000, 32'h8000_0000, 1'b1, 64'h4000_0000_0000_0000, 1'b1, 1'b0);
    issue(32'h8000_0000, 32'h7FFF_FFFF, 1'b1, 64'hC000_0000_8000_0000, 1'b1, 1'b0);
    issue(32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b1, 64'h3FFF_FFFF_0000_0001, 1'b1, 1'b0);
    issue(32'd123, 32'd456, 1'b1, 64'sd56088, 1'b1, 1'b0);
    issue(32'd7, -32'sd1, 1'b1, -64'sd7, 1'b1, 1'b0);
    drain();

    // Start pulsed mid-operation with different operands must be ignored.
    issue(32'd7, 32'd6, 1'b1, 64'sd42, 1'b1, 1'b0);
    repeat (4) @(negedge clk);
    a_in  = 32'd9;
    b_in  = 32'd9;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    drain();

    // Start held through the done cycle: second op accepted immediately.
    issue(-32'sd7, 32'd9, 1'b1, -64'sd63, 1'b1, 1'b1);
    issue(32'd100, 32'd100, 1'b1, 64'sd10000, 1'b1, 1'b0);
    drain();
    check1("issue_period", 64'(last_done_cyc - prev_done_cyc), 64'(LAT + 1));

    // Reset mid-operation aborts without a done.
    issue(32'd3, 32'd5, 1'b1, 64'sd15, 1'b0, 1'b0);
    repeat (7) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check1("abort_busy", {63'd0, busy}, 64'd0);
    check1("abort_done", {63'd0, done}, 64'd0);
    check1("abort_product", product, 64'd0);
    n0 = n_done;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (LAT + 4) @(negedge clk);
    check1("abort_no_done", 64'(n_done), 64'(n0));

    issue(-32'sd1, -32'sd1, 1'b1, 64'sd1, 1'b1, 1'b0);
`ifdef BOOTH_UNSIGNED_MODE_EN
    issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 64'hFFFF_FFFE_0000_0001, 1'b1, 1'b0);
    issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 64'sd1, 1'b1, 1'b0);
`endif
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
